// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the MIPS run/reset sequencer.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        TMO  = 3'd4
    } state_e;

    localparam int DEFAULT_HALT_REPEAT = 3;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/observation bundle between the bench top and the run sequencer.
interface cpu_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic             commit_valid;
    logic [PC_W-1:0]  commit_pc;
    logic             cpu_reset;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] commit_count;
    logic [PC_W-1:0]  halt_pc;

    modport slave (
        input  start, commit_valid, commit_pc,
        output cpu_reset, running, done, timeout, cycle_count, commit_count, halt_pc
    );

    modport master (
        output start, commit_valid, commit_pc,
        input  cpu_reset, running, done, timeout, cycle_count, commit_count, halt_pc
    );
endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign q = cnt_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/reset sequencer: stretches reset to the core, counts cycles and commits,
// and stops on a self-loop halt or on a cycle budget.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 4,
    parameter int HALT_REPEAT  = DEFAULT_HALT_REPEAT,
    parameter int MAX_CYCLES   = 100000,
    parameter int AUTO_START   = 1
) (
    input  logic          clk,
    input  logic          reset,
    cpu_run_ctrl_if.slave bus
);
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int HW = $clog2(HALT_REPEAT + 1);
    localparam logic [RW-1:0]    RST_LAST = RW'(RESET_CYCLES);
    localparam logic [HW-1:0]    HALT_N   = HW'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_CYCLES - 1);

    state_e           state_q, state_d;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [HW-1:0]    rep_cnt_q, rep_cnt_d;
    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             running_q, running_d;
    logic             cnt_clr, cyc_en, cmt_en;
    logic [CNT_W-1:0] cyc_cnt, cmt_cnt;

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk(clk), .reset(reset), .clr(cnt_clr), .en(cyc_en), .q(cyc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cmt_cnt (
        .clk(clk), .reset(reset), .clr(cnt_clr), .en(cmt_en), .q(cmt_cnt)
    );

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        rep_cnt_d = rep_cnt_q;
        last_pc_d = last_pc_q;
        halt_pc_d = halt_pc_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cnt_clr   = 1'b0;
        cyc_en    = 1'b0;
        cmt_en    = 1'b0;

        unique case (state_q)
            IDLE, DONE, TMO: begin
                if (bus.start) begin
                    state_d   = RST;
                    rst_cnt_d = '0;
                    rep_cnt_d = '0;
                    last_pc_d = '0;
                    halt_pc_d = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            RST: begin
                // Counting to RESET_CYCLES (not -1) lines RUN up with cpu_reset
                // falling, so cycle_count starts at 0 on the first running edge.
                if (rst_cnt_q == RST_LAST)
                    state_d = RUN;
                else
                    rst_cnt_d = rst_cnt_q + 1'b1;
            end
            RUN: begin
                cyc_en = 1'b1;
                if (bus.commit_valid) begin
                    cmt_en = 1'b1;
                    // rep_cnt == 0 marks "no PC seen yet", so a first commit at
                    // PC 0 does not match the reset value of last_pc.
                    if ((rep_cnt_q != '0) && (bus.commit_pc == last_pc_q)) begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end else begin
                        rep_cnt_d = 1;
                        last_pc_d = bus.commit_pc;
                    end
                    if (rep_cnt_d == HALT_N) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        halt_pc_d = bus.commit_pc;
                    end
                end
                if ((state_d != DONE) && (cyc_cnt == MAX_LAST)) begin
                    state_d   = TMO;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cpu_reset_d = ((state_q == IDLE) || (state_q == RST)) && (state_d != RUN);
        running_d   = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= (AUTO_START != 0) ? RST : IDLE;
            rst_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            last_pc_q   <= '0;
            halt_pc_q   <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            last_pc_q   <= last_pc_d;
            halt_pc_q   <= halt_pc_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
        end
    end

    assign bus.cpu_reset    = cpu_reset_q;
    assign bus.running      = running_q;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.cycle_count  = cyc_cnt;
    assign bus.commit_count = cmt_cnt;
    assign bus.halt_pc      = halt_pc_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: three configurations sharing one clock.
module tb_cpu_run_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    cpu_run_ctrl_if #(.PC_W(32), .CNT_W(32)) ia();
    cpu_run_ctrl_if #(.PC_W(32), .CNT_W(32)) ib();
    cpu_run_ctrl_if #(.PC_W(32), .CNT_W(4))  ic();

    cpu_run_ctrl #(.PC_W(32), .CNT_W(32), .RESET_CYCLES(4), .HALT_REPEAT(3),
                   .MAX_CYCLES(10), .AUTO_START(1)) dut_a (.clk(clk), .reset(rst_a), .bus(ia));
    cpu_run_ctrl #(.PC_W(32), .CNT_W(32), .RESET_CYCLES(4), .HALT_REPEAT(3),
                   .MAX_CYCLES(10), .AUTO_START(0)) dut_b (.clk(clk), .reset(rst_b), .bus(ib));
    cpu_run_ctrl #(.PC_W(32), .CNT_W(4), .RESET_CYCLES(4), .HALT_REPEAT(3),
                   .MAX_CYCLES(15), .AUTO_START(1)) dut_c (.clk(clk), .reset(rst_c), .bus(ic));

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a = 0; rst_b = 0; rst_c = 0;
        ia.start = 0; ia.commit_valid = 0; ia.commit_pc = '0;
        ib.start = 0; ib.commit_valid = 0; ib.commit_pc = '0;
        ic.start = 0; ic.commit_valid = 0; ic.commit_pc = '0;
        step(2);
        total++; if ({ia.cpu_reset, ia.running, ia.done, ia.timeout} !== 4'b1000) begin bad++; $display("FAIL reset_flags act=%b exp=1000", {ia.cpu_reset, ia.running, ia.done, ia.timeout}); end
        total++; if ({ia.cycle_count, ia.commit_count, ia.halt_pc} !== 96'd0) begin bad++; $display("FAIL reset_regs act=%h exp=0", {ia.cycle_count, ia.commit_count, ia.halt_pc}); end
        rst_a = 1; rst_b = 1; rst_c = 1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            total++; if ({ia.cpu_reset, ia.running} !== 2'b10) begin bad++; $display("FAIL reset_stretch k=%0d act=%b exp=10", k, {ia.cpu_reset, ia.running}); end
        end
        step(1);
        total++; if ({ia.cpu_reset, ia.running} !== 2'b01) begin bad++; $display("FAIL reset_run_entry act=%b exp=01", {ia.cpu_reset, ia.running}); end
        total++; if (ia.cycle_count !== 32'd0) begin bad++; $display("FAIL reset_cyc0 act=%0d exp=0", ia.cycle_count); end
        total++; if ({ib.cpu_reset, ib.running} !== 2'b10) begin bad++; $display("FAIL noauto_idle act=%b exp=10", {ib.cpu_reset, ib.running}); end
    endtask

    task automatic test_halt();
        logic [31:0] pcs [6];
        bit          vld [6];
        int          n;
        pcs = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h0, 32'h3008};
        vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        n = 0;
        for (int i = 0; i < 6; i++) begin
            ia.commit_valid = vld[i];
            ia.commit_pc    = pcs[i];
            if (vld[i]) begin n++; exp_q.push_back(32'(n)); end
            step(1);
            if (vld[i]) begin
                exp_v = exp_q.pop_front();
                total++; if (ia.commit_count !== exp_v) begin bad++; $display("FAIL halt_commit_cnt i=%0d act=%0d exp=%0d", i, ia.commit_count, exp_v); end
            end
            total++; if (ia.done !== 1'(i == 5)) begin bad++; $display("FAIL halt_done i=%0d act=%b exp=%b", i, ia.done, i == 5); end
        end
        ia.commit_valid = 0;
        total++; if (ia.halt_pc !== 32'h3008) begin bad++; $display("FAIL halt_pc act=%h exp=3008", ia.halt_pc); end
        total++; if ({ia.running, ia.cpu_reset, ia.timeout} !== 3'b000) begin bad++; $display("FAIL halt_flags act=%b exp=000", {ia.running, ia.cpu_reset, ia.timeout}); end
        total++; if (ia.cycle_count !== 32'd6) begin bad++; $display("FAIL halt_cyc act=%0d exp=6", ia.cycle_count); end
        ia.commit_valid = 1; ia.commit_pc = 32'h5000;
        step(2);
        ia.commit_valid = 0;
        total++; if ({ia.commit_count, ia.cycle_count} !== {32'd5, 32'd6}) begin bad++; $display("FAIL done_freeze act=%0d/%0d exp=5/6", ia.commit_count, ia.cycle_count); end
        total++; if (ia.done !== 1'b1) begin bad++; $display("FAIL done_sticky act=%b exp=1", ia.done); end
    endtask

    task automatic test_restart();
        ia.start = 1; step(1); ia.start = 0;
        total++; if ({ia.done, ia.cpu_reset, ia.running} !== 3'b000) begin bad++; $display("FAIL restart_flags act=%b exp=000", {ia.done, ia.cpu_reset, ia.running}); end
        total++; if ({ia.halt_pc, ia.cycle_count, ia.commit_count} !== 96'd0) begin bad++; $display("FAIL restart_clear act=%h exp=0", {ia.halt_pc, ia.cycle_count, ia.commit_count}); end
        for (int k = 1; k <= 4; k++) begin
            ia.start = (k == 2);
            step(1);
            ia.start = 0;
            total++; if ({ia.cpu_reset, ia.running} !== 2'b10) begin bad++; $display("FAIL restart_rst k=%0d act=%b exp=10", k, {ia.cpu_reset, ia.running}); end
        end
        step(1);
        total++; if ({ia.cpu_reset, ia.running, ia.cycle_count} !== {2'b01, 32'd0}) begin bad++; $display("FAIL restart_run act=%b/%0d exp=01/0", {ia.cpu_reset, ia.running}, ia.cycle_count); end
        ia.start = 1; step(1); ia.start = 0;
        total++; if ({ia.cpu_reset, ia.running, ia.cycle_count} !== {2'b01, 32'd1}) begin bad++; $display("FAIL start_in_run act=%b/%0d exp=01/1", {ia.cpu_reset, ia.running}, ia.cycle_count); end
    endtask

    task automatic test_timeout();
        int n;
        for (int c = 2; c <= 10; c++) begin
            step(1);
            total++; if (ia.timeout !== 1'(c == 10)) begin bad++; $display("FAIL tmo_edge c=%0d act=%b exp=%b", c, ia.timeout, c == 10); end
        end
        total++; if ({ia.cycle_count, ia.done, ia.running} !== {32'd10, 2'b00}) begin bad++; $display("FAIL tmo_state act=%0d/%b exp=10/00", ia.cycle_count, {ia.done, ia.running}); end
        step(2);
        total++; if ({ia.cycle_count, ia.timeout} !== {32'd10, 1'b1}) begin bad++; $display("FAIL tmo_freeze act=%0d/%b exp=10/1", ia.cycle_count, ia.timeout); end
        ia.start = 1; step(1); ia.start = 0;
        total++; if (ia.timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear act=%b exp=0", ia.timeout); end
        step(5);
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            ia.commit_valid = (c >= 8);
            ia.commit_pc    = 32'h4000;
            if (c >= 8) begin n++; exp_q.push_back(32'(n)); end
            step(1);
            if (c >= 8) begin
                exp_v = exp_q.pop_front();
                total++; if (ia.commit_count !== exp_v) begin bad++; $display("FAIL race_commit_cnt c=%0d act=%0d exp=%0d", c, ia.commit_count, exp_v); end
            end
        end
        ia.commit_valid = 0;
        total++; if ({ia.done, ia.timeout} !== 2'b10) begin bad++; $display("FAIL race_halt_wins act=%b exp=10", {ia.done, ia.timeout}); end
        total++; if ({ia.cycle_count, ia.halt_pc} !== {32'd10, 32'h4000}) begin bad++; $display("FAIL race_regs act=%0d/%h exp=10/4000", ia.cycle_count, ia.halt_pc); end
    endtask

    task automatic test_reset_midrun();
        ia.start = 1; step(1); ia.start = 0;
        step(5);
        for (int c = 1; c <= 5; c++) begin
            ia.commit_valid = (c <= 2);
            ia.commit_pc    = 32'h6000 + 32'(4 * c);
            step(1);
        end
        ia.commit_valid = 0;
        total++; if ({ia.cycle_count, ia.commit_count} !== {32'd5, 32'd2}) begin bad++; $display("FAIL midrun_pre act=%0d/%0d exp=5/2", ia.cycle_count, ia.commit_count); end
        rst_a = 0; step(1); rst_a = 1;
        total++; if ({ia.cpu_reset, ia.running, ia.cycle_count, ia.commit_count} !== {2'b10, 64'd0}) begin bad++; $display("FAIL midrun_reset act=%b/%0d/%0d exp=10/0/0", {ia.cpu_reset, ia.running}, ia.cycle_count, ia.commit_count); end
        ib.start = 1; step(1); ib.start = 0;
        step(5);
        total++; if (ib.running !== 1'b1) begin bad++; $display("FAIL noauto_run act=%b exp=1", ib.running); end
        step(5);
        total++; if (ib.cycle_count !== 32'd5) begin bad++; $display("FAIL noauto_cyc act=%0d exp=5", ib.cycle_count); end
        rst_b = 0; step(1); rst_b = 1;
        total++; if ({ib.cpu_reset, ib.running, ib.cycle_count} !== {2'b10, 32'd0}) begin bad++; $display("FAIL noauto_reset act=%b/%0d exp=10/0", {ib.cpu_reset, ib.running}, ib.cycle_count); end
        step(8);
        total++; if ({ib.cpu_reset, ib.running} !== 2'b10) begin bad++; $display("FAIL noauto_stay_idle act=%b exp=10", {ib.cpu_reset, ib.running}); end
        ib.start = 1; step(1); ib.start = 0;
        step(4);
        total++; if (ib.running !== 1'b0) begin bad++; $display("FAIL noauto_early act=%b exp=0", ib.running); end
        step(1);
        total++; if ({ib.cpu_reset, ib.running} !== 2'b01) begin bad++; $display("FAIL noauto_start act=%b exp=01", {ib.cpu_reset, ib.running}); end
    endtask

    task automatic test_saturation();
        int n;
        total++; if (ic.timeout !== 1'b1) begin bad++; $display("FAIL sat_prior_tmo act=%b exp=1", ic.timeout); end
        ic.start = 1; step(1); ic.start = 0;
        step(5);
        total++; if ({ic.running, ic.cycle_count, ic.commit_count} !== 9'b1_0000_0000) begin bad++; $display("FAIL sat_start act=%b/%0d/%0d exp=1/0/0", ic.running, ic.cycle_count, ic.commit_count); end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            ic.commit_valid = 1;
            ic.commit_pc    = 32'h100 + 32'(4 * i);
            if (i < 15) n = (n == 15) ? 15 : n + 1;
            exp_q.push_back(32'(n));
            step(1);
            exp_v = exp_q.pop_front();
            total++; if ({28'd0, ic.commit_count} !== exp_v) begin bad++; $display("FAIL sat_commit_cnt i=%0d act=%0d exp=%0d", i, ic.commit_count, exp_v); end
            total++; if (ic.timeout !== 1'(i >= 14)) begin bad++; $display("FAIL sat_tmo i=%0d act=%b exp=%b", i, ic.timeout, i >= 14); end
        end
        ic.commit_valid = 0;
        total++; if ({ic.cycle_count, ic.running, ic.done} !== {4'd15, 2'b00}) begin bad++; $display("FAIL sat_final act=%0d/%b exp=15/00", ic.cycle_count, {ic.running, ic.done}); end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_restart();
        test_timeout();
        test_reset_midrun();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
